// File: rtl/phase_seq_if.sv
// Control and status bundle for the one-hot phase sequencer.
interface phase_seq_if #(
  parameter int unsigned NPHASE  = 5,
  parameter int unsigned DWELL_W = 4,
  parameter int unsigned CNT_W   = 8
);
  localparam int unsigned IDX_W = $clog2(NPHASE);

  logic               start;
  logic               stop;
  logic               abort;
  logic               hold;
  logic               oneshot;
  logic [DWELL_W-1:0] dwell;
  logic [NPHASE-1:0]  q;
  logic [IDX_W-1:0]   phase_idx;
  logic               busy;
  logic               done;
  logic               wrap;
  logic [CNT_W-1:0]   cycles;

  modport master (
    output start, stop, abort, hold, oneshot, dwell,
    input  q, phase_idx, busy, done, wrap, cycles
  );

  modport slave (
    input  start, stop, abort, hold, oneshot, dwell,
    output q, phase_idx, busy, done, wrap, cycles
  );
endinterface

// File: rtl/phase_seq.sv
// One-hot phase sequencer: NPHASE phases of dwell+1 cycles each, with hold,
// one-shot, sticky end-of-pass stop, immediate abort and a saturating pass count.
module phase_seq #(
  parameter int unsigned NPHASE  = 5,
  parameter int unsigned DWELL_W = 4,
  parameter int unsigned CNT_W   = 8
) (
  input  logic        CLK,
  input  logic        RSTN,
  phase_seq_if.slave  bus
);
  localparam int unsigned IDX_W = $clog2(NPHASE);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state, state_n;
  logic [NPHASE-1:0]  q, q_n;
  logic [IDX_W-1:0]   idx, idx_n;
  logic               busy, busy_n;
  logic               done, done_n;
  logic               wrap, wrap_n;
  logic [CNT_W-1:0]   cycles, cycles_n;
  logic [DWELL_W-1:0] dcnt, dcnt_n;
  logic [DWELL_W-1:0] dwell_l, dwell_l_n;
  logic               oneshot_l, oneshot_l_n;
  logic               stop_pend, stop_pend_n;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state     <= IDLE;
      q         <= '0;
      idx       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      wrap      <= 1'b0;
      cycles    <= '0;
      dcnt      <= '0;
      dwell_l   <= '0;
      oneshot_l <= 1'b0;
      stop_pend <= 1'b0;
    end else begin
      state     <= state_n;
      q         <= q_n;
      idx       <= idx_n;
      busy      <= busy_n;
      done      <= done_n;
      wrap      <= wrap_n;
      cycles    <= cycles_n;
      dcnt      <= dcnt_n;
      dwell_l   <= dwell_l_n;
      oneshot_l <= oneshot_l_n;
      stop_pend <= stop_pend_n;
    end
  end

  always_comb begin
    state_n     = state;
    q_n         = q;
    idx_n       = idx;
    busy_n      = busy;
    done_n      = 1'b0;
    wrap_n      = 1'b0;
    cycles_n    = cycles;
    dcnt_n      = dcnt;
    dwell_l_n   = dwell_l;
    oneshot_l_n = oneshot_l;
    stop_pend_n = stop_pend;

    if (bus.abort) begin
      state_n     = IDLE;
      q_n         = '0;
      idx_n       = '0;
      busy_n      = 1'b0;
      dcnt_n      = '0;
      stop_pend_n = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            state_n     = RUN;
            q_n         = NPHASE'(1);
            idx_n       = '0;
            busy_n      = 1'b1;
            dcnt_n      = '0;
            cycles_n    = '0;
            dwell_l_n   = bus.dwell;
            oneshot_l_n = bus.oneshot;
            stop_pend_n = bus.stop;
          end
        end
        RUN: begin
          if (bus.stop) stop_pend_n = 1'b1;
          if (!bus.hold) begin
            if (dcnt < dwell_l) begin
              dcnt_n = dcnt + 1'b1;
            end else begin
              dcnt_n = '0;
              if (q[NPHASE-1]) begin
                if (cycles != '1) cycles_n = cycles + 1'b1;
                // A stop raised in this very cycle still ends the pass here.
                if (oneshot_l || stop_pend || bus.stop) begin
                  state_n     = IDLE;
                  q_n         = '0;
                  idx_n       = '0;
                  busy_n      = 1'b0;
                  done_n      = 1'b1;
                  stop_pend_n = 1'b0;
                end else begin
                  q_n    = NPHASE'(1);
                  idx_n  = '0;
                  wrap_n = 1'b1;
                end
              end else begin
                q_n   = {q[NPHASE-2:0], 1'b0};
                idx_n = idx + 1'b1;
              end
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign bus.q         = q;
  assign bus.phase_idx = idx;
  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.wrap      = wrap;
  assign bus.cycles    = cycles;
endmodule

// File: tb/tb_phase_seq.sv
// Directed self-checking bench for phase_seq (NPHASE=5, DWELL_W=4, CNT_W=8).
module tb_phase_seq;
  logic CLK = 1'b0;
  logic RSTN = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 CLK = ~CLK;

  phase_seq_if #(.NPHASE(5), .DWELL_W(4), .CNT_W(8)) bus ();

  phase_seq #(.NPHASE(5), .DWELL_W(4), .CNT_W(8)) dut (
    .CLK (CLK),
    .RSTN(RSTN),
    .bus (bus)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    bus.start = 0; bus.stop = 0; bus.abort = 0; bus.hold = 0;
    bus.oneshot = 0; bus.dwell = '0;
    RSTN = 0;
    #1;
    tests++; if (bus.q !== 5'b0) begin fails++; $display("FAIL reset_q got=%b exp=00000", bus.q); end
    tests++; if (bus.phase_idx !== 3'd0) begin fails++; $display("FAIL reset_idx got=%0d exp=0", bus.phase_idx); end
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    tests++; if (bus.done !== 1'b0) begin fails++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    tests++; if (bus.wrap !== 1'b0) begin fails++; $display("FAIL reset_wrap got=%b exp=0", bus.wrap); end
    tests++; if (bus.cycles !== 8'd0) begin fails++; $display("FAIL reset_cycles got=%0d exp=0", bus.cycles); end
    tick(); tick();
    RSTN = 1;
    tick();
  endtask

  task automatic test_single_pass();
    logic [4:0] exp;
    bus.dwell = 4'd0; bus.oneshot = 0; bus.start = 1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      bus.start = 0;
      exp = 5'd1 << (i - 1);
      tests++; if (bus.q !== exp) begin fails++; $display("FAIL single_q cyc=%0d got=%b exp=%b", i, bus.q, exp); end
      tests++; if (bus.phase_idx !== 3'(i - 1)) begin fails++; $display("FAIL single_idx cyc=%0d got=%0d exp=%0d", i, bus.phase_idx, i - 1); end
      tests++; if (bus.busy !== 1'b1 || bus.wrap !== 1'b0) begin fails++; $display("FAIL single_busy cyc=%0d busy=%b wrap=%b exp busy=1 wrap=0", i, bus.busy, bus.wrap); end
      if (i == 5) bus.stop = 1;
    end
    tick();
    bus.stop = 0;
    tests++; if (bus.q !== 5'b0 || bus.done !== 1'b1) begin fails++; $display("FAIL single_end q=%b done=%b exp q=00000 done=1", bus.q, bus.done); end
    tests++; if (bus.cycles !== 8'd1 || bus.busy !== 1'b0) begin fails++; $display("FAIL single_cnt cycles=%0d busy=%b exp cycles=1 busy=0", bus.cycles, bus.busy); end
    tick();
    tests++; if (bus.done !== 1'b0) begin fails++; $display("FAIL single_done_pulse got=%b exp=0", bus.done); end
  endtask

  task automatic test_start_stop();
    bus.dwell = 4'd0; bus.oneshot = 0; bus.start = 1; bus.stop = 1;
    tick();
    bus.start = 0; bus.stop = 0;
    for (int t = 1; t <= 5; t++) tick();
    tests++; if (bus.done !== 1'b1 || bus.q !== 5'b0 || bus.wrap !== 1'b0) begin fails++; $display("FAIL start_stop done=%b q=%b wrap=%b exp done=1 q=00000 wrap=0", bus.done, bus.q, bus.wrap); end
    tick();
  endtask

  task automatic test_oneshot();
    logic [4:0] exp;
    bus.dwell = 4'd2; bus.oneshot = 1; bus.start = 1;
    tick();
    bus.start = 0; bus.dwell = 4'd0; bus.oneshot = 0;
    for (int t = 0; t <= 14; t++) begin
      exp = 5'd1 << (t / 3);
      tests++; if (bus.q !== exp) begin fails++; $display("FAIL oneshot_q t=%0d got=%b exp=%b", t, bus.q, exp); end
      tests++; if (bus.wrap !== 1'b0 || bus.done !== 1'b0) begin fails++; $display("FAIL oneshot_pulse t=%0d wrap=%b done=%b exp 0 0", t, bus.wrap, bus.done); end
      bus.start = (t == 7);
      tick();
    end
    bus.start = 0;
    tests++; if (bus.q !== 5'b0 || bus.done !== 1'b1 || bus.cycles !== 8'd1) begin fails++; $display("FAIL oneshot_end q=%b done=%b cycles=%0d exp 00000 1 1", bus.q, bus.done, bus.cycles); end
    tick();
  endtask

  task automatic test_wrap();
    logic [4:0] exp;
    bus.dwell = 4'd0; bus.oneshot = 0; bus.start = 1;
    tick();
    bus.start = 0;
    for (int t = 1; t <= 17; t++) begin
      tick();
      exp = 5'd1 << (t % 5);
      tests++; if (bus.q !== exp) begin fails++; $display("FAIL wrap_q t=%0d got=%b exp=%b", t, bus.q, exp); end
      tests++; if (bus.wrap !== (t % 5 == 0)) begin fails++; $display("FAIL wrap_pulse t=%0d got=%b exp=%b", t, bus.wrap, (t % 5 == 0)); end
      tests++; if (bus.cycles !== 8'(t / 5)) begin fails++; $display("FAIL wrap_cycles t=%0d got=%0d exp=%0d", t, bus.cycles, t / 5); end
    end
    bus.stop = 1;
    tick();
    bus.stop = 0;
    tests++; if (bus.q !== 5'b01000 || bus.busy !== 1'b1) begin fails++; $display("FAIL wrap_stop_notrunc q=%b busy=%b exp 01000 1", bus.q, bus.busy); end
    tick();
    tests++; if (bus.q !== 5'b10000 || bus.done !== 1'b0) begin fails++; $display("FAIL wrap_stop_last q=%b done=%b exp 10000 0", bus.q, bus.done); end
    tick();
    tests++; if (bus.q !== 5'b0 || bus.done !== 1'b1 || bus.wrap !== 1'b0 || bus.cycles !== 8'd4) begin fails++; $display("FAIL wrap_stop_end q=%b done=%b wrap=%b cycles=%0d exp 00000 1 0 4", bus.q, bus.done, bus.wrap, bus.cycles); end
    tick();
  endtask

  task automatic test_hold();
    logic [4:0] exp;
    bit seen;
    bus.dwell = 4'd1; bus.oneshot = 1; bus.start = 1;
    tick();
    bus.start = 0;
    for (int t = 0; t <= 10; t++) begin
      exp = (t < 2) ? 5'b00001 : (t < 4) ? 5'b00010 : (t < 10) ? 5'b00100 : 5'b01000;
      tests++; if (bus.q !== exp) begin fails++; $display("FAIL hold_q t=%0d got=%b exp=%b", t, bus.q, exp); end
      bus.hold = (t >= 4 && t <= 7);
      if (t < 10) tick();
    end
    bus.hold = 0;
    seen = 0;
    for (int k = 0; k < 10 && !seen; k++) begin
      tick();
      if (bus.done === 1'b1) seen = 1;
    end
    tests++; if (!seen || bus.cycles !== 8'd1) begin fails++; $display("FAIL hold_finish done_seen=%b cycles=%0d exp 1 1", seen, bus.cycles); end
    tick();
  endtask

  task automatic test_abort();
    bus.dwell = 4'd0; bus.oneshot = 0; bus.start = 1;
    tick();
    bus.start = 0;
    for (int t = 1; t <= 13; t++) tick();
    tests++; if (bus.q !== 5'b01000 || bus.cycles !== 8'd2) begin fails++; $display("FAIL abort_pre q=%b cycles=%0d exp 01000 2", bus.q, bus.cycles); end
    bus.abort = 1;
    tick();
    bus.abort = 0;
    tests++; if (bus.q !== 5'b0 || bus.busy !== 1'b0 || bus.phase_idx !== 3'd0) begin fails++; $display("FAIL abort_q q=%b busy=%b idx=%0d exp 00000 0 0", bus.q, bus.busy, bus.phase_idx); end
    tests++; if (bus.done !== 1'b0 || bus.wrap !== 1'b0 || bus.cycles !== 8'd2) begin fails++; $display("FAIL abort_flags done=%b wrap=%b cycles=%0d exp 0 0 2", bus.done, bus.wrap, bus.cycles); end
    bus.start = 1;
    tick();
    bus.start = 0;
    tests++; if (bus.cycles !== 8'd0 || bus.q !== 5'b00001) begin fails++; $display("FAIL abort_restart cycles=%0d q=%b exp 0 00001", bus.cycles, bus.q); end
    // A pending stop must not survive an abort.
    bus.stop = 1;
    tick();
    bus.stop = 0; bus.abort = 1;
    tick();
    bus.abort = 0; bus.start = 1;
    tick();
    bus.start = 0;
    for (int t = 1; t <= 5; t++) tick();
    tests++; if (bus.wrap !== 1'b1 || bus.busy !== 1'b1 || bus.q !== 5'b00001) begin fails++; $display("FAIL abort_clears_stop wrap=%b busy=%b q=%b exp 1 1 00001", bus.wrap, bus.busy, bus.q); end
    bus.abort = 1;
    tick();
    bus.abort = 0;
  endtask

  task automatic test_async_reset();
    bus.dwell = 4'd3; bus.oneshot = 0; bus.start = 1;
    tick();
    bus.start = 0;
    tick();
    #2;
    RSTN = 0;
    #1;
    tests++; if (bus.q !== 5'b0 || bus.busy !== 1'b0 || bus.phase_idx !== 3'd0) begin fails++; $display("FAIL async_reset q=%b busy=%b idx=%0d exp 00000 0 0", bus.q, bus.busy, bus.phase_idx); end
    tick();
    RSTN = 1;
    bus.start = 1; bus.abort = 1;
    tick();
    bus.start = 0; bus.abort = 0;
    tests++; if (bus.q !== 5'b0 || bus.busy !== 1'b0) begin fails++; $display("FAIL start_abort q=%b busy=%b exp 00000 0", bus.q, bus.busy); end
    tick();
    tests++; if (bus.q !== 5'b0 || bus.busy !== 1'b0) begin fails++; $display("FAIL start_abort_idle q=%b busy=%b exp 00000 0", bus.q, bus.busy); end
  endtask

  initial begin
    test_reset();
    test_single_pass();
    test_start_stop();
    test_oneshot();
    test_wrap();
    test_hold();
    test_abort();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached tests=%0d", tests);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/phase_seq.md
Name: phase_seq

Overview:
Parametrised one-hot phase sequencer; next generation of the fixed 5-phase start/stop sequencer. It steps a one-hot phase vector through NPHASE phases. Each phase lasts a programmable number of cycles. Adds one-shot mode, hold, immediate abort, a sticky stop request, and a completed-pass counter. It drives phase-ordered datapath enables in the counter/display subsystems.

Parameters:
NPHASE, 5, number of phases; must be >= 2
DWELL_W, 4, width of dwell input; each phase lasts dwell+1 cycles
CNT_W, 8, width of completed-pass counter

Ports:
CLK  in  1  system clock, rising edge
RSTN  in  1  asynchronous active-low reset
start  in  1  begin sequencing; honoured only in IDLE
stop  in  1  request stop at the end of the current pass; sticky
abort  in  1  immediate return to IDLE
hold  in  1  freeze the phase and the dwell counter while high
oneshot  in  1  1: run one pass then stop; sampled with start
dwell  in  DWELL_W  cycles-per-phase minus 1; sampled with start
q  out  NPHASE  one-hot phase vector; all zero in IDLE
phase_idx  out  clog2(NPHASE)  index of the active phase; 0 in IDLE
busy  out  1  high in RUN
done  out  1  1-cycle pulse on a normal finish
wrap  out  1  1-cycle pulse on a last-phase to phase-0 wrap
cycles  out  CNT_W  completed passes since the last start; saturating

Behaviour:
- Clock and reset: one clock CLK; reset RSTN is asynchronous and active-low.
- Reset values: state=IDLE, q=0, phase_idx=0, busy=0, done=0, wrap=0, cycles=0. Internal dwell counter, latched dwell, latched oneshot and stop_pending are all 0.
- States: IDLE and RUN. All outputs are registered.
- IDLE, start=1, abort=0:
  - Next edge: RUN, q=1 (phase 0), busy=1, dwell counter=0, cycles=0.
  - dwell and oneshot are latched on this edge.
  - stop_pending is set to the value of stop in that same cycle.
- RUN, hold=0:
  - If the dwell counter is below the latched dwell, it increments.
  - If it equals the latched dwell, the phase ends: the counter clears and q shifts left one place.
  - With dwell=0 the sequencer advances one phase per cycle.
- End of the last phase (q[NPHASE-1]=1 and the phase ends); cycles increments, saturating at all-ones:
  - If oneshot_latched=1 or stop_pending=1, or stop=1 in this cycle: next edge goes to IDLE with q=0, busy=0, done=1 for one cycle, stop_pending cleared.
  - Otherwise: q=1, wrap=1 for one cycle.
- RUN, hold=1: q and the dwell counter are frozen. stop is still latched and abort is still honoured. done and wrap do not fire.
- stop=1 at any cycle in RUN sets stop_pending. It takes effect only at the end of the last phase; a pass is never truncated.
- abort=1 (highest priority, any state):
  - Next edge: IDLE, q=0, busy=0, stop_pending=0.
  - done=0 and wrap=0; cycles keeps its value.
  - abort together with start in IDLE: the sequencer stays in IDLE.
- start in RUN is ignored; it neither restarts nor re-latches.
- dwell and oneshot changing during RUN have no effect until the next start.
- RSTN asserted mid-run: all outputs return to reset values immediately, without waiting for a clock edge.
- phase_idx always equals the binary index of q's set bit.
- q is never multi-hot.

Test Plan:
- NPHASE=5, dwell=0, oneshot=0. Pulse start at cycle 0; assert stop in the cycle where q=10000.
  - Required: q=00001,00010,00100,01000,10000 on cycles 1-5.
  - Required: q=0, done=1, cycles=1 on cycle 6.
- dwell=2, oneshot=1, start:
  - Required: each phase is held exactly 3 cycles; q=0 and done pulses 15 cycles after entry to phase 0.
  - Required: wrap is never asserted; cycles=1.
- dwell=0, oneshot=0, no stop for 3 passes:
  - Required: wrap pulses each time q returns to 00001; cycles=1,2,3.
  - Then a stop pulse while q=00100: the current pass completes, done pulses, and cycles=4.
- Assert hold for 4 cycles while q=00100, dwell=1:
  - Required: q remains 00100 for 4 extra cycles.
  - Required: the phase then completes its remaining dwell; total time in phase = 2+4 cycles.
- abort while q=01000 with cycles=2:
  - Required: next cycle q=0, busy=0, done=0, cycles=2.
  - Required: a subsequent start clears cycles to 0.
- Assert RSTN low mid-phase, asynchronously between clock edges:
  - Required: q=0, busy=0 immediately.
  - Required: start plus abort in the same IDLE cycle leaves q=0.
